pwm_capture: RTL
================

Name: pwm_capture

Overview:
- Receive-side counterpart of the transmit PWM generator.
- Measures an incoming square wave (ultrasonic receiver comparator output, or a loopback of the 40 kHz drive): period, high time, and loss of signal.
- Sits between the asynchronous receiver pin and the echo/ranging logic.
- Emits one measurement per complete input period, with a 1-cycle valid strobe.

Parameters:
- MAX_PERIOD, 4095: longest measurable period in clk_in cycles; also the loss-of-signal timeout. CNT_W = $clog2(MAX_PERIOD+1) (12 by default).
- SYNC_STAGES, 2: flip-flop synchronizer depth on sig_in. Minimum 2.
- FILTER_CYCLES, 4: consecutive stable synchronized samples required before the filtered signal changes. Minimum 1.

Ports:
- clk_in  input  1  system clock (100 MHz)
- rst_n_in  input  1  asynchronous, active-low reset
- sig_in  input  1  asynchronous PWM/pulse input
- period_out  output  CNT_W  cycles between the last two accepted rising edges
- high_out  output  CNT_W  cycles from the last accepted rising edge to the following falling edge
- valid_out  output  1  one-cycle strobe; period_out/high_out updated in the same cycle
- no_signal_out  output  1  level; high when no valid measurement since reset or last timeout

Behaviour:
- Reset (rst_n_in low, asynchronous): all registers clear.
  - period_out=0, high_out=0, valid_out=0, no_signal_out=1, filtered signal=0, FSM=SEEK.
  - Release is used synchronously only.
- Conditioning:
  - sig_in passes through SYNC_STAGES flops to give sig_sync.
  - Filter counter tracks how long sig_sync has differed from sig_filt. It resets whenever sig_sync equals sig_filt.
  - sig_filt toggles once sig_sync has differed for FILTER_CYCLES consecutive cycles.
  - Pulses shorter than FILTER_CYCLES never reach sig_filt.
  - Latency from sig_in edge to sig_filt edge: SYNC_STAGES+FILTER_CYCLES cycles (±1 for metastability sampling).
- Edge detect: rise = sig_filt & ~sig_filt_d; fall = ~sig_filt & sig_filt_d. Both are single-cycle.
- Counter cnt (CNT_W bits):
  - Loaded with 1 on a rise cycle; otherwise incremented.
  - Saturates at MAX_PERIOD.
  - For rises detected at cycles t0 and t1, cnt sampled at t1 equals t1−t0.
- FSM states SEEK, HIGH, LOW:
  - SEEK: wait for rise, then go to HIGH with cnt:=1. No output. The first partial period is always discarded.
  - HIGH:
    - On fall: high_cap:=cnt, go to LOW.
    - On cnt==MAX_PERIOD with no fall: go to SEEK and set no_signal_out:=1.
  - LOW:
    - On rise: period_out:=cnt, high_out:=high_cap, valid_out:=1 for one cycle, no_signal_out:=0, cnt:=1, stay in HIGH.
    - On cnt==MAX_PERIOD with no rise: go to SEEK and set no_signal_out:=1.
- Timing: valid_out and both data outputs are registered. They assert in the cycle after the rise-detect cycle, and data is held until the next valid_out.
- Timeouts:
  - A timeout does not clear period_out/high_out.
  - valid_out never asserts on a timeout.
  - A rise in the same cycle that cnt reaches MAX_PERIOD counts as a valid edge; the rise wins.
- Period exactly MAX_PERIOD is reported. Longer periods time out.
- Constant high or constant low input ends in SEEK with no_signal_out=1 within MAX_PERIOD cycles of the last edge.
- A reset asserted mid-measurement discards the partial measurement. After release, the first valid_out requires two new filtered rises.
- high_out is always ≥1 and always < period_out.

Decomposition:
- Package pwm_capture_pkg:
  - typedef enum logic [1:0] {SEEK, HIGH, LOW} cap_state_t;
  - default constants DEFAULT_MAX_PERIOD=4095 and DEFAULT_FILTER_CYCLES=4.
- Sub-module pwm_in_filter:
  - Contains the synchronizer, glitch filter and edge detect.
  - Ports: clk_in, rst_n_in, sig_in, sig_filt_out, rise_out, fall_out.
  - Parameters: SYNC_STAGES, FILTER_CYCLES.
- The top level holds cnt, high_cap, the FSM and the output registers.

Test Plan:
- Steady 40 kHz input (period 2500, high 1250, 10 periods) -> valid_out pulses exactly every 2500 cycles; every strobe reports period_out=2500, high_out=1250; first strobe one cycle after the second filtered rise; no_signal_out falls at the first strobe.
- Duty sweep at period 1000 with high 1, 5, 500, 995 (FILTER_CYCLES=4) -> high 5/500/995 reported exactly; 1-cycle pulses ignored, and while they persist there are no rises, ending in a timeout after 4095 cycles.
- Injected 3-cycle glitch low in the middle of the high phase (period 2500/1250) -> no extra valid_out; reported values unchanged.
- Input stops (held low) after 3 good periods -> no_signal_out=1 exactly 4095 cycles after the last rise; period_out/high_out hold 2500/1250; no valid_out. Restart -> first valid_out on the second new rise.
- Period exactly 4095 vs 4096 -> 4095 is reported; 4096 gives a timeout and no valid_out.
- rst_n_in pulsed low asynchronously mid-HIGH for 7 ns (not clock-aligned) -> outputs go immediately to period_out=0, high_out=0, valid_out=0, no_signal_out=1; after release, measurement resumes correctly after two rises.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared types and default constants for the PWM capture block.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } cap_state_t;

    localparam int DEFAULT_MAX_PERIOD    = 4095;
    localparam int DEFAULT_FILTER_CYCLES = 4;
    localparam int DEFAULT_SYNC_STAGES   = 2;

endpackage

// File: rtl/pwm_capture_if.sv
// Measurement result bus from the capture block to the echo/ranging logic.
interface pwm_capture_if #(
    parameter int CNT_W = 12
);
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             valid_out;
    logic             no_signal_out;

    modport master (output period_out, output high_out, output valid_out, output no_signal_out);
    modport slave  (input  period_out, input  high_out, input  valid_out, input  no_signal_out);
endinterface

// File: rtl/pwm_in_filter.sv
// Input conditioning: synchronizer, glitch filter and single-cycle edge strobes.
module pwm_in_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic sig_in,
    output logic sig_filt_out,
    output logic rise_out,
    output logic fall_out
);
    localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [FW-1:0]          filt_cnt_r;
    logic                   filt_r;
    logic                   filt_d_r;
    logic                   sig_sync_s;

    assign sig_sync_s = sync_r[SYNC_STAGES-1];

    // Metastability synchronizer chain
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
        end
    end

    // Glitch filter: the filtered level only flips after FILTER_CYCLES differing samples
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            filt_cnt_r <= {FW{1'b0}};
            filt_r     <= 1'b0;
            filt_d_r   <= 1'b0;
        end else begin
            filt_d_r <= filt_r;
            if (sig_sync_s == filt_r) begin
                filt_cnt_r <= {FW{1'b0}};
            end else if (filt_cnt_r == FILT_LAST) begin
                filt_cnt_r <= {FW{1'b0}};
                filt_r     <= ~filt_r;
            end else begin
                filt_cnt_r <= filt_cnt_r + {{(FW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign sig_filt_out = filt_r;
    assign rise_out     = filt_r & ~filt_d_r;
    assign fall_out     = ~filt_r & filt_d_r;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of a conditioned square wave and flags loss of signal.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int MAX_PERIOD    = DEFAULT_MAX_PERIOD,
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int FILTER_CYCLES = DEFAULT_FILTER_CYCLES,
    localparam int CNT_W        = $clog2(MAX_PERIOD + 1)
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    input  logic           sig_in,
    pwm_capture_if.master  cap
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             sig_filt_s;
    logic             rise_s;
    logic             fall_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] high_cap_r;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] high_r;
    logic             valid_r;
    logic             no_sig_r;
    cap_state_t       state_r;

    pwm_in_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .sig_in       (sig_in),
        .sig_filt_out (sig_filt_s),
        .rise_out     (rise_s),
        .fall_out     (fall_s)
    );

    // Cycle counter since the last accepted rise, saturating at MAX_PERIOD
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (rise_s) begin
            cnt_r <= ONE_C;
        end else if (cnt_r != MAX_C) begin
            cnt_r <= cnt_r + ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Measurement FSM; a rise coinciding with saturation is still a valid edge
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r    <= SEEK;
            high_cap_r <= {CNT_W{1'b0}};
            period_r   <= {CNT_W{1'b0}};
            high_r     <= {CNT_W{1'b0}};
            valid_r    <= 1'b0;
            no_sig_r   <= 1'b1;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                SEEK: begin
                    if (rise_s) begin
                        state_r <= HIGH;
                    end else begin
                        state_r <= SEEK;
                    end
                end
                HIGH: begin
                    if (fall_s) begin
                        high_cap_r <= cnt_r;
                        state_r    <= LOW;
                    end else if (sig_filt_s && (cnt_r == MAX_C)) begin
                        no_sig_r <= 1'b1;
                        state_r  <= SEEK;
                    end else begin
                        state_r <= HIGH;
                    end
                end
                LOW: begin
                    if (rise_s) begin
                        period_r <= cnt_r;
                        high_r   <= high_cap_r;
                        valid_r  <= 1'b1;
                        no_sig_r <= 1'b0;
                        state_r  <= HIGH;
                    end else if (cnt_r == MAX_C) begin
                        no_sig_r <= 1'b1;
                        state_r  <= SEEK;
                    end else begin
                        state_r <= LOW;
                    end
                end
                default: begin
                    state_r <= SEEK;
                end
            endcase
        end
    end

    assign cap.period_out    = period_r;
    assign cap.high_out      = high_r;
    assign cap.valid_out     = valid_r;
    assign cap.no_signal_out = no_sig_r;

endmodule
